// File: rtl/qmc_mem_responder.sv
// qmc_mem_responder: memory-side endpoint that runs load/store/amoswap requests against a local RAM.
// Define QMC_MEM_RESPONDER_STATS_EN to add the stat_req_o/stat_err_o request and error counters.
module qmc_mem_responder #(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 28,
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 3,
    parameter int mem_els_p      = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      fwd_v_i,
    input  logic [1:0]                fwd_op_i,
    input  logic [addr_width_p-1:0]   fwd_addr_i,
    input  logic [data_width_p-1:0]   fwd_data_i,
    input  logic [data_width_p/8-1:0] fwd_mask_i,
    input  logic [x_cord_width_p-1:0] fwd_src_x_i,
    input  logic [y_cord_width_p-1:0] fwd_src_y_i,
    output logic                      fwd_ready_o,
    output logic                      rev_v_o,
    output logic [1:0]                rev_type_o,
    output logic [data_width_p-1:0]   rev_data_o,
    output logic                      rev_err_o,
    output logic [x_cord_width_p-1:0] rev_dst_x_o,
    output logic [y_cord_width_p-1:0] rev_dst_y_o,
`ifdef QMC_MEM_RESPONDER_STATS_EN
    output logic [31:0]               stat_req_o,
    output logic [31:0]               stat_err_o,
`endif
    input  logic                      rev_ready_i
);

    localparam int MaskW = data_width_p / 8;
    localparam int IdxW  = $clog2(mem_els_p);

    localparam logic [1:0] OP_STORE = 2'd0;
    localparam logic [1:0] OP_SWAP  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e                    state_q;
    logic [1:0]                op_q;
    logic [addr_width_p-1:0]   addr_q;
    logic [data_width_p-1:0]   wdata_q;
    logic [MaskW-1:0]          mask_q;
    logic [x_cord_width_p-1:0] srcX_q;
    logic [y_cord_width_p-1:0] srcY_q;

    logic                      fwdReady_q;
    logic                      revV_q;
    logic [1:0]                revType_q;
    logic                      revErr_q;
    logic [x_cord_width_p-1:0] revDstX_q;
    logic [y_cord_width_p-1:0] revDstY_q;
    logic                      dataSel_q;
    logic [data_width_p-1:0]   rdData_q;

    logic [data_width_p-1:0]   mem_q [mem_els_p];

    logic                      accept;
    logic                      inRange;
    logic                      isErr;
    logic                      doWrite;
    logic [IdxW-1:0]           idx;

    assign accept  = (state_q == IDLE) && fwdReady_q && fwd_v_i;
    // mem_els_p is a power of two, so any set bit above the index field means out of range
    assign inRange = (addr_q >> IdxW) == '0;
    assign idx     = addr_q[IdxW-1:0];
    assign isErr   = !inRange || (op_q == OP_RSVD);
    assign doWrite = (state_q == EXEC) && reset_n_i && inRange
                     && ((op_q == OP_STORE) || (op_q == OP_SWAP));

    // RAM is never reset; the read returns the pre-write word, which amoswap relies on
    always_ff @(posedge clk_i) begin
        if (state_q == EXEC) begin
            rdData_q <= mem_q[idx];
        end
        if (doWrite) begin
            for (int b = 0; b < MaskW; b++) begin
                if ((op_q == OP_SWAP) || mask_q[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            fwdReady_q <= 1'b0;
            revV_q     <= 1'b0;
            revType_q  <= '0;
            revErr_q   <= 1'b0;
            revDstX_q  <= '0;
            revDstY_q  <= '0;
            dataSel_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    fwdReady_q <= 1'b1;
                    if (accept) begin
                        op_q       <= fwd_op_i;
                        addr_q     <= fwd_addr_i;
                        wdata_q    <= fwd_data_i;
                        mask_q     <= fwd_mask_i;
                        srcX_q     <= fwd_src_x_i;
                        srcY_q     <= fwd_src_y_i;
                        fwdReady_q <= 1'b0;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    revV_q    <= 1'b1;
                    revType_q <= op_q;
                    revErr_q  <= isErr;
                    dataSel_q <= !isErr && (op_q != OP_STORE);
                    revDstX_q <= srcX_q;
                    revDstY_q <= srcY_q;
                    state_q   <= RESP;
                end
                RESP: begin
                    if (rev_ready_i) begin
                        revV_q     <= 1'b0;
                        fwdReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fwd_ready_o = fwdReady_q;
    assign rev_v_o     = revV_q;
    assign rev_type_o  = revType_q;
    assign rev_err_o   = revErr_q;
    assign rev_dst_x_o = revDstX_q;
    assign rev_dst_y_o = revDstY_q;
    assign rev_data_o  = dataSel_q ? rdData_q : '0;

`ifdef QMC_MEM_RESPONDER_STATS_EN
    logic [31:0] statReq_q;
    logic [31:0] statErr_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            statReq_q <= '0;
            statErr_q <= '0;
        end else begin
            if (accept) begin
                statReq_q <= statReq_q + 32'd1;
            end
            if ((state_q == RESP) && rev_ready_i && revErr_q) begin
                statErr_q <= statErr_q + 32'd1;
            end
        end
    end

    assign stat_req_o = statReq_q;
    assign stat_err_o = statErr_q;
`endif

endmodule

// File: tb/tb_qmc_mem_responder.sv
// tb_qmc_mem_responder: directed requests against qmc_mem_responder, checked by a word-level memory
// model plus literal expectations; stat counters are checked when QMC_MEM_RESPONDER_STATS_EN is defined.
module tb_qmc_mem_responder;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        fwd_v_i;
    logic [1:0]  fwd_op_i;
    logic [27:0] fwd_addr_i;
    logic [31:0] fwd_data_i;
    logic [3:0]  fwd_mask_i;
    logic [3:0]  fwd_src_x_i;
    logic [2:0]  fwd_src_y_i;
    logic        fwd_ready_o;
    logic        rev_v_o;
    logic [1:0]  rev_type_o;
    logic [31:0] rev_data_o;
    logic        rev_err_o;
    logic [3:0]  rev_dst_x_o;
    logic [2:0]  rev_dst_y_o;
    logic        rev_ready_i;
`ifdef QMC_MEM_RESPONDER_STATS_EN
    logic [31:0] stat_req_o;
    logic [31:0] stat_err_o;
`endif

    always #5 clk_i = ~clk_i;

    qmc_mem_responder dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .fwd_v_i     (fwd_v_i),
        .fwd_op_i    (fwd_op_i),
        .fwd_addr_i  (fwd_addr_i),
        .fwd_data_i  (fwd_data_i),
        .fwd_mask_i  (fwd_mask_i),
        .fwd_src_x_i (fwd_src_x_i),
        .fwd_src_y_i (fwd_src_y_i),
        .fwd_ready_o (fwd_ready_o),
        .rev_v_o     (rev_v_o),
        .rev_type_o  (rev_type_o),
        .rev_data_o  (rev_data_o),
        .rev_err_o   (rev_err_o),
        .rev_dst_x_o (rev_dst_x_o),
        .rev_dst_y_o (rev_dst_y_o),
`ifdef QMC_MEM_RESPONDER_STATS_EN
        .stat_req_o  (stat_req_o),
        .stat_err_o  (stat_err_o),
`endif
        .rev_ready_i (rev_ready_i)
    );

    typedef struct {
        logic [1:0]  rtype;
        logic [31:0] data;
        logic        err;
        logic [3:0]  x;
        logic [2:0]  y;
    } resp_t;

    resp_t       expQ[$];
    logic [31:0] modelMem [int];
    int          testsRun = 0;
    int          testsFailed = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Word-level view of the memory: what each request must return and how it changes the RAM
    function automatic void modelExec(input logic [1:0] op, input logic [27:0] addr,
                                      input logic [31:0] data, input logic [3:0] mask,
                                      input logic [3:0] x, input logic [2:0] y);
        resp_t       r;
        logic [31:0] old;
        int          a;
        r.rtype = op;
        r.x     = x;
        r.y     = y;
        r.err   = 1'b0;
        r.data  = 32'h0;
        a       = int'(addr);
        if (op == 2'd3 || addr >= 28'd1024) begin
            r.err = 1'b1;
        end else begin
            old = modelMem.exists(a) ? modelMem[a] : 32'h0;
            if (op == 2'd1) begin
                r.data = old;
            end else if (op == 2'd2) begin
                r.data      = old;
                modelMem[a] = data;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) old[8*b +: 8] = data[8*b +: 8];
                end
                modelMem[a] = old;
            end
        end
        expQ.push_back(r);
    endfunction

    // Every cycle a response is presented it must match the oldest outstanding model response
    always @(negedge clk_i) begin
        if (rev_v_o) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousResp", 32'(rev_v_o), 32'd0);
            end else begin
                checkOutput("revType", 32'(rev_type_o), 32'(expQ[0].rtype));
                checkOutput("revData", rev_data_o, expQ[0].data);
                checkOutput("revErr", 32'(rev_err_o), 32'(expQ[0].err));
                checkOutput("revDstX", 32'(rev_dst_x_o), 32'(expQ[0].x));
                checkOutput("revDstY", 32'(rev_dst_y_o), 32'(expQ[0].y));
                checkOutput("readyInResp", 32'(fwd_ready_o), 32'd0);
                if (rev_ready_i && reset_n_i) void'(expQ.pop_front());
            end
        end
        if (!reset_n_i) expQ.delete();
    end

    // Issues one request, checks response latency, then either completes the handshake or resets in RESP
    task automatic applyStimulus(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                                 input logic [3:0] mask, input logic [3:0] x, input logic [2:0] y,
                                 input int holdCycles, input bit resetInResp,
                                 output logic [31:0] respData, output logic respErr);
        bit accepted = 1'b0;
        bit seen = 1'b0;
        int lat = 0;
        respData = 32'h0;
        respErr  = 1'b0;
        @(posedge clk_i); #1;
        fwd_v_i     = 1'b1;
        fwd_op_i    = op;
        fwd_addr_i  = addr;
        fwd_data_i  = data;
        fwd_mask_i  = mask;
        fwd_src_x_i = x;
        fwd_src_y_i = y;
        for (int c = 0; c < 10 && !accepted; c++) begin
            @(negedge clk_i);
            if (fwd_ready_o) accepted = 1'b1;
        end
        if (!accepted) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            fwd_v_i = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        fwd_v_i = 1'b0;
        modelExec(op, addr, data, mask, x, y);
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk_i);
            if (rev_v_o) begin
                seen     = 1'b1;
                lat      = c;
                respData = rev_data_o;
                respErr  = rev_err_o;
            end
        end
        if (!seen) begin
            checkOutput("respTimeout", 32'd0, 32'd1);
            expQ.delete();
            return;
        end
        checkOutput("respLatency", 32'(lat), 32'd2);
        repeat (holdCycles) @(negedge clk_i);
        if (resetInResp) begin
            @(posedge clk_i); #1;
            reset_n_i = 1'b0;
            @(posedge clk_i); #1;
            @(negedge clk_i);
            checkOutput("revVAfterReset", 32'(rev_v_o), 32'd0);
            checkOutput("readyAfterReset", 32'(fwd_ready_o), 32'd0);
            checkOutput("dataAfterReset", rev_data_o, 32'd0);
            checkOutput("errAfterReset", 32'(rev_err_o), 32'd0);
`ifdef QMC_MEM_RESPONDER_STATS_EN
            checkOutput("statReqReset", stat_req_o, 32'd0);
            checkOutput("statErrReset", stat_err_o, 32'd0);
`endif
            @(posedge clk_i); #1;
            reset_n_i = 1'b1;
            @(negedge clk_i);
        end else begin
            @(posedge clk_i); #1;
            rev_ready_i = 1'b1;
            @(negedge clk_i);
            @(posedge clk_i); #1;
            rev_ready_i = 1'b0;
            @(negedge clk_i);
            checkOutput("revVDropped", 32'(rev_v_o), 32'd0);
            checkOutput("readyAfterHs", 32'(fwd_ready_o), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        reset_n_i   = 1'b0;
        fwd_v_i     = 1'b0;
        fwd_op_i    = 2'd0;
        fwd_addr_i  = '0;
        fwd_data_i  = '0;
        fwd_mask_i  = '0;
        fwd_src_x_i = '0;
        fwd_src_y_i = '0;
        rev_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rstRevV", 32'(rev_v_o), 32'd0);
        checkOutput("rstReady", 32'(fwd_ready_o), 32'd0);
        checkOutput("rstErr", 32'(rev_err_o), 32'd0);
        checkOutput("rstData", rev_data_o, 32'd0);
        checkOutput("rstType", 32'(rev_type_o), 32'd0);
        checkOutput("rstDstX", 32'(rev_dst_x_o), 32'd0);
        checkOutput("rstDstY", 32'(rev_dst_y_o), 32'd0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;

        applyStimulus(2'd0, 28'd0, 32'h0BADF00D, 4'hF, 4'd1, 3'd1, 0, 1'b0, d, e);
        applyStimulus(2'd1, 28'd0, 32'h0, 4'h0, 4'd1, 3'd1, 0, 1'b0, d, e);
        checkOutput("load0Init", d, 32'h0BADF00D);

        applyStimulus(2'd0, 28'd5, 32'hDEADBEEF, 4'hF, 4'd1, 3'd0, 0, 1'b0, d, e);
        checkOutput("store5Data", d, 32'h0);
        checkOutput("store5Err", 32'(e), 32'd0);
        applyStimulus(2'd1, 28'd5, 32'h0, 4'h0, 4'd1, 3'd0, 0, 1'b0, d, e);
        checkOutput("load5Full", d, 32'hDEADBEEF);

        applyStimulus(2'd0, 28'd5, 32'h000000AA, 4'h1, 4'd2, 3'd1, 0, 1'b0, d, e);
        applyStimulus(2'd1, 28'd5, 32'h0, 4'h0, 4'd2, 3'd1, 0, 1'b0, d, e);
        checkOutput("load5Byte0", d, 32'hDEADBEAA);

        applyStimulus(2'd0, 28'd7, 32'h00000011, 4'hF, 4'd0, 3'd0, 0, 1'b0, d, e);
        applyStimulus(2'd2, 28'd7, 32'h00000022, 4'h0, 4'd0, 3'd0, 0, 1'b0, d, e);
        checkOutput("swap7Old", d, 32'h00000011);
        applyStimulus(2'd1, 28'd7, 32'h0, 4'h0, 4'd0, 3'd0, 0, 1'b0, d, e);
        checkOutput("load7New", d, 32'h00000022);

        applyStimulus(2'd1, 28'd1024, 32'h0, 4'h0, 4'd5, 3'd4, 0, 1'b0, d, e);
        checkOutput("oorLoadErr", 32'(e), 32'd1);
        checkOutput("oorLoadData", d, 32'h0);
        applyStimulus(2'd3, 28'd0, 32'hFFFFFFFF, 4'hF, 4'd5, 3'd4, 0, 1'b0, d, e);
        checkOutput("rsvdErr", 32'(e), 32'd1);
        applyStimulus(2'd0, 28'h0000405, 32'hFFFFFFFF, 4'hF, 4'd6, 3'd5, 0, 1'b0, d, e);
        checkOutput("oorStoreErr", 32'(e), 32'd1);
        applyStimulus(2'd2, 28'h8000000, 32'hFFFFFFFF, 4'h0, 4'd6, 3'd5, 0, 1'b0, d, e);
        checkOutput("oorSwapErr", 32'(e), 32'd1);
        applyStimulus(2'd1, 28'd0, 32'h0, 4'h0, 4'd1, 3'd1, 0, 1'b0, d, e);
        checkOutput("load0After", d, 32'h0BADF00D);
        applyStimulus(2'd1, 28'd5, 32'h0, 4'h0, 4'd1, 3'd1, 0, 1'b0, d, e);
        checkOutput("load5NoAlias", d, 32'hDEADBEAA);

        applyStimulus(2'd1, 28'd5, 32'h0, 4'h0, 4'd3, 3'd2, 10, 1'b0, d, e);
        checkOutput("holdLoad5", d, 32'hDEADBEAA);

        applyStimulus(2'd0, 28'd5, 32'h11223344, 4'hA, 4'd15, 3'd7, 0, 1'b0, d, e);
        applyStimulus(2'd1, 28'd5, 32'h0, 4'h0, 4'd15, 3'd7, 0, 1'b0, d, e);
        checkOutput("load5Mask1010", d, 32'h11AD33AA);

        applyStimulus(2'd0, 28'd9, 32'h00000055, 4'hF, 4'd3, 3'd2, 0, 1'b0, d, e);
        applyStimulus(2'd2, 28'd9, 32'h00000066, 4'h0, 4'd3, 3'd2, 2, 1'b1, d, e);
        checkOutput("swap9Old", d, 32'h00000055);
        applyStimulus(2'd1, 28'd9, 32'h0, 4'h0, 4'd3, 3'd2, 0, 1'b0, d, e);
        checkOutput("load9AfterReset", d, 32'h00000066);
`ifdef QMC_MEM_RESPONDER_STATS_EN
        checkOutput("statReqOne", stat_req_o, 32'd1);
        checkOutput("statErrZero", stat_err_o, 32'd0);
`endif

        repeat (2) @(negedge clk_i);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
